// File: rtl/core_sequencer_rv32.sv
// Multi-cycle RV32 instruction sequencer: fetch, decode, execute, memory and writeback,
// with a memory wait timeout and an absorbing error state.
module core_sequencer_rv32 #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        memory_ready,
  input  logic [31:0] memory_read_value,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        writes_rd,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] load_store_address,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic [31:0] load_data,
  output logic [31:0] memory_read_address,
  output logic        read_enable,
  output logic        write_enable,
  output logic        register_write_enable,
  output logic        instruction_retired,
  output logic        bus_error,
  output logic [2:0]  state,
  output logic [31:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   wait_q;
  logic            wait_expired;
  logic            misaligned;

  assign wait_expired = (wait_q == CW'(TIMEOUT - 1));
  assign misaligned   = branch_taken && (branch_target[1:0] != 2'b00);
  assign bus_error    = (state_q == S_ERROR);
  assign state        = state_q;

  // Enables are decoded from the registered state, so an asynchronous reset drops them at once.
  always_comb begin
    state_d               = state_q;
    read_enable           = 1'b0;
    write_enable          = 1'b0;
    register_write_enable = 1'b0;
    instruction_retired   = 1'b0;
    memory_read_address   = pc;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_FETCH;
      end
      S_FETCH: begin
        read_enable = 1'b1;
        if (memory_ready)      state_d = S_DECODE;
        else if (wait_expired) state_d = S_ERROR;
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = (is_load || is_store) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        // A load/store conflict resolves to a load: never write when reading.
        memory_read_address = load_store_address;
        read_enable         = is_load;
        write_enable        = is_store && !is_load;
        if (memory_ready)      state_d = S_WRITEBACK;
        else if (wait_expired) state_d = S_ERROR;
      end
      S_WRITEBACK: begin
        if (misaligned) begin
          state_d = S_ERROR;
        end else begin
          register_write_enable = writes_rd;
          instruction_retired   = 1'b1;
          state_d               = enable ? S_FETCH : S_IDLE;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pc            <= PC_RESET;
      instruction   <= '0;
      load_data     <= '0;
      retired_count <= '0;
      wait_q        <= '0;
    end else begin
      state_q <= state_d;
      // Wait counter only runs while stalled on memory; any other cycle re-arms it.
      if ((state_q == S_FETCH || state_q == S_MEMORY) && !memory_ready)
        wait_q <= wait_q + 1'b1;
      else
        wait_q <= '0;
      if (state_q == S_FETCH && memory_ready)
        instruction <= memory_read_value;
      if (state_q == S_MEMORY && memory_ready && is_load)
        load_data <= memory_read_value;
      if (state_q == S_WRITEBACK && !misaligned) begin
        pc            <= branch_taken ? branch_target : pc + 32'd4;
        retired_count <= retired_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_core_sequencer_rv32.sv
// Bench for core_sequencer_rv32: directed and randomized instructions checked against a
// per-instruction transaction model (expected pc, retire count, captured data, per-cycle outputs).
module tb_core_sequencer_rv32;

  localparam logic [31:0] PC_RST = 32'h0000_0000;
  localparam int          TMO    = 15;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
                         S_MEMORY = 3'd4, S_WB = 3'd5, S_ERR = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        memory_ready = 1'b0;
  logic [31:0] memory_read_value = '0;
  logic        is_load = 1'b0, is_store = 1'b0, writes_rd = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0, load_store_address = '0;
  logic [31:0] pc, instruction, load_data, memory_read_address, retired_count;
  logic        read_enable, write_enable, register_write_enable, instruction_retired, bus_error;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_count, m_instr, m_load;

  always #5 clk = ~clk;

  core_sequencer_rv32 #(.PC_RESET(PC_RST), .TIMEOUT(TMO)) dut (
    .clock(clk), .reset_n(reset_n), .enable(enable), .memory_ready(memory_ready),
    .memory_read_value(memory_read_value), .is_load(is_load), .is_store(is_store),
    .writes_rd(writes_rd), .branch_taken(branch_taken), .branch_target(branch_target),
    .load_store_address(load_store_address), .pc(pc), .instruction(instruction),
    .load_data(load_data), .memory_read_address(memory_read_address),
    .read_enable(read_enable), .write_enable(write_enable),
    .register_write_enable(register_write_enable), .instruction_retired(instruction_retired),
    .bus_error(bus_error), .state(state), .retired_count(retired_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already applied; checks this cycle, then advances one clock.
  task automatic step(input logic [2:0] st, input logic re, input logic we, input logic rwe,
                      input logic ret, input logic [31:0] addr);
    #1;
    chk("state", {29'd0, state}, {29'd0, st});
    chk("read_enable", {31'd0, read_enable}, {31'd0, re});
    chk("write_enable", {31'd0, write_enable}, {31'd0, we});
    chk("register_write_enable", {31'd0, register_write_enable}, {31'd0, rwe});
    chk("instruction_retired", {31'd0, instruction_retired}, {31'd0, ret});
    chk("bus_error", {31'd0, bus_error}, {31'd0, (st == S_ERR)});
    chk("memory_read_address", memory_read_address, addr);
    chk("pc", pc, m_pc);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_state", {29'd0, state}, {29'd0, S_IDLE});
    chk("rst_pc", pc, PC_RST);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_retired_count", retired_count, 32'd0);
    chk("rst_read_enable", {31'd0, read_enable}, 32'd0);
    chk("rst_write_enable", {31'd0, write_enable}, 32'd0);
    chk("rst_reg_we", {31'd0, register_write_enable}, 32'd0);
    chk("rst_retired", {31'd0, instruction_retired}, 32'd0);
    chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_pc = PC_RST; m_count = '0; m_instr = '0; m_load = '0;
  endtask

  // From IDLE: linger with enable low, then raise enable to start fetching.
  task automatic go(input int idle_cycles);
    for (int i = 0; i < idle_cycles; i++) begin
      enable = 1'b0;
      memory_ready = 1'($urandom_range(0, 1));
      step(S_IDLE, 0, 0, 0, 0, m_pc);
    end
    enable = 1'b1;
    step(S_IDLE, 0, 0, 0, 0, m_pc);
  endtask

  // One whole instruction starting in FETCH; jit randomizes enable in cycles where it is ignored.
  task automatic run_instr(input int fst, input int mst, input logic ld, input logic sto,
                           input logic wr, input logic br, input logic [31:0] tgt,
                           input logic [31:0] lsa, input logic [31:0] rdata,
                           input logic [31:0] ins, input logic en_exec, input logic jit);
    logic mis;
    mis = br && (tgt[1:0] != 2'b00);
    is_load = ld; is_store = sto; writes_rd = wr;
    branch_taken = br; branch_target = tgt; load_store_address = lsa;
    for (int i = 0; i < fst; i++) begin
      enable = jit ? 1'($urandom_range(0, 1)) : 1'b1;
      memory_ready = 1'b0; memory_read_value = $urandom;
      step(S_FETCH, 1, 0, 0, 0, m_pc);
    end
    memory_ready = 1'b1; memory_read_value = ins;
    step(S_FETCH, 1, 0, 0, 0, m_pc);
    m_instr = ins;
    chk("instruction", instruction, m_instr);
    enable = jit ? 1'($urandom_range(0, 1)) : 1'b1;
    memory_ready = 1'($urandom_range(0, 1)); memory_read_value = $urandom;
    step(S_DECODE, 0, 0, 0, 0, m_pc);
    enable = en_exec;
    step(S_EXECUTE, 0, 0, 0, 0, m_pc);
    if (ld || sto) begin
      for (int i = 0; i < mst; i++) begin
        enable = jit ? 1'($urandom_range(0, 1)) : en_exec;
        memory_ready = 1'b0; memory_read_value = $urandom;
        step(S_MEMORY, ld, sto && !ld, 0, 0, lsa);
      end
      memory_ready = 1'b1; memory_read_value = rdata;
      step(S_MEMORY, ld, sto && !ld, 0, 0, lsa);
      if (ld) m_load = rdata;
      chk("load_data", load_data, m_load);
    end
    enable = en_exec;
    memory_ready = 1'($urandom_range(0, 1));
    step(S_WB, 0, 0, wr && !mis, !mis, m_pc);
    if (!mis) begin
      m_count = m_count + 32'd1;
      m_pc = br ? tgt : m_pc + 32'd4;
    end
    chk("retired_count", retired_count, m_count);
    chk("pc_after", pc, m_pc);
    chk("next_state", {29'd0, state}, {29'd0, mis ? S_ERR : (en_exec ? S_FETCH : S_IDLE)});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] t;
    logic        en, br, ld, sto;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    pulse_reset();

    // Single ALU instruction, then two more back to back
    go(0);
    run_instr(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0000_0013, 1, 0);
    run_instr(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0010_0093, 1, 0);
    run_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0020_0113, 1, 0);
    chk("pc_is_12", pc, 32'd12);

    // Load with three stall cycles, plain store, and load/store conflict
    run_instr(0, 3, 1, 0, 1, 0, 32'h0, 32'h100, 32'hDEAD_BEEF, 32'h1000_2083, 1, 0);
    chk("load_deadbeef", load_data, 32'hDEAD_BEEF);
    run_instr(1, 2, 0, 1, 0, 0, 32'h0, 32'h200, 32'h5555_AAAA, 32'h0011_2023, 1, 0);
    run_instr(0, 1, 1, 1, 1, 0, 32'h0, 32'h300, 32'h1234_5678, 32'h0001_2183, 1, 0);

    // Aligned branch
    run_instr(0, 0, 0, 0, 0, 1, 32'h40, 32'h0, 32'h0, 32'h0000_006F, 1, 0);
    chk("pc_is_40", pc, 32'h40);

    // Randomized instruction mix
    for (int n = 0; n < 40; n++) begin
      ld  = 1'($urandom_range(0, 2) == 0);
      sto = 1'($urandom_range(0, 2) == 0);
      br  = 1'($urandom_range(0, 3) == 0);
      en  = 1'($urandom_range(0, 4) != 0);
      t = $urandom; t[1:0] = 2'b00;
      run_instr($urandom_range(0, 5), $urandom_range(0, 5), ld, sto, 1'($urandom_range(0, 1)),
                br, t, $urandom, $urandom, $urandom, en, 1);
      if (!en) go($urandom_range(0, 3));
    end

    // pc wrap, then enable dropped in EXECUTE still retires and parks in IDLE
    run_instr(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0000_006F, 1, 0);
    run_instr(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0000_0013, 0, 0);
    chk("pc_wrapped", pc, 32'h0);
    go(2);

    // Longest tolerated stalls in both memory phases
    run_instr(TMO - 1, TMO - 1, 1, 0, 1, 0, 32'h0, 32'h44, 32'hCAFE_F00D, 32'h0440_2003, 1, 0);

    // Misaligned branch target faults without retiring; error is sticky
    t = pc;
    run_instr(0, 0, 0, 0, 1, 1, 32'h42, 32'h0, 32'h0, 32'h0000_006F, 1, 0);
    chk("pc_unchanged_on_fault", pc, t);
    for (int i = 0; i < 3; i++) begin
      enable = 1'b1; memory_ready = 1'b1;
      step(S_ERR, 0, 0, 0, 0, m_pc);
    end
    pulse_reset();

    // Fetch that never completes times out
    go(0);
    for (int i = 0; i < TMO; i++) begin
      memory_ready = 1'b0;
      step(S_FETCH, 1, 0, 0, 0, m_pc);
    end
    for (int i = 0; i < 3; i++) begin
      memory_ready = 1'b1;
      step(S_ERR, 0, 0, 0, 0, m_pc);
    end
    pulse_reset();

    // Reset in the middle of a fetch drops read_enable before any clock edge
    go(0);
    memory_ready = 1'b0;
    step(S_FETCH, 1, 0, 0, 0, m_pc);
    #2;
    pulse_reset();

    // Reset in the middle of a stalled store drops write_enable immediately
    go(0);
    is_load = 1'b0; is_store = 1'b1; writes_rd = 1'b0; branch_taken = 1'b0;
    load_store_address = 32'h80;
    memory_ready = 1'b1; memory_read_value = 32'h0000_2023;
    step(S_FETCH, 1, 0, 0, 0, m_pc);
    step(S_DECODE, 0, 0, 0, 0, m_pc);
    step(S_EXECUTE, 0, 0, 0, 0, m_pc);
    memory_ready = 1'b0;
    step(S_MEMORY, 0, 1, 0, 0, 32'h80);
    #2;
    pulse_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_sequencer_rv32.md
CORE_SEQUENCER_RV32 -- requirements
Module: core_sequencer_rv32

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000, the PC value loaded at reset.
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum cycles to wait for memory_ready before error.
REQ-003 SHALL have port clock  in  1  system clock, rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  in  1  run permission, sampled in IDLE and WRITEBACK.
REQ-006 SHALL have port memory_ready  in  1  memory completes the current access this cycle.
REQ-007 SHALL have port memory_read_value  in  32  read data, valid with memory_ready.
REQ-008 SHALL have ports is_load, is_store, writes_rd  in  1 each  decode class flags, valid from EXECUTE onward.
REQ-009 SHALL have ports branch_taken  in  1, branch_target  in  32, load_store_address  in  32  execute results, valid in EXECUTE/MEMORY/WRITEBACK.
REQ-010 SHALL have outputs pc 32, instruction 32, load_data 32, memory_read_address 32.
REQ-011 SHALL have outputs read_enable, write_enable, register_write_enable, instruction_retired, bus_error (1 each), state 3, retired_count 32.

Function
REQ-012 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, ERROR=6; the state output equals the current state.
REQ-013 IDLE SHALL go to FETCH when enable=1 and otherwise stay in IDLE.
REQ-014 FETCH SHALL drive read_enable=1 and memory_read_address=pc; on memory_ready it SHALL register memory_read_value into instruction and go to DECODE.
REQ-015 DECODE SHALL last exactly one cycle, then go to EXECUTE.
REQ-016 EXECUTE SHALL last one cycle; it SHALL go to MEMORY if is_load or is_store, else to WRITEBACK.
REQ-017 MEMORY SHALL drive memory_read_address=load_store_address, read_enable=is_load, and write_enable=is_store and not is_load; on memory_ready it SHALL capture memory_read_value into load_data (loads only) and go to WRITEBACK.
REQ-018 If is_load and is_store are both 1, SHALL treat the access as a load; write_enable stays 0.
REQ-019 WRITEBACK SHALL last one cycle and drive register_write_enable=writes_rd.
REQ-020 WRITEBACK SHALL pulse instruction_retired=1 and increment retired_count, wrapping 32'hFFFF_FFFF to 0.
REQ-021 WRITEBACK SHALL update pc to branch_target if branch_taken, else pc+4 mod 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-022 After WRITEBACK, SHALL go to FETCH if enable=1, else to IDLE.
REQ-023 When branch_taken=1 and branch_target[1:0]!=0 in WRITEBACK, SHALL go to ERROR, leave pc unchanged, and not retire.
REQ-024 A wait counter SHALL clear on entry to FETCH/MEMORY and increment each cycle memory_ready=0; reaching TIMEOUT SHALL go to ERROR.
REQ-025 ERROR SHALL be absorbing until reset; bus_error=1 there; all enables 0.
REQ-026 Outside their named states, read_enable, write_enable, register_write_enable, and instruction_retired SHALL be 0; memory_read_address SHALL be pc.
REQ-027 enable deasserting mid-instruction SHALL NOT abort it; the sequencer stops only at the WRITEBACK→IDLE boundary.

Reset
REQ-028 While reset_n=0, SHALL be asynchronously in state IDLE with pc=PC_RESET; instruction, load_data, and retired_count=0; all 1-bit outputs=0.
REQ-029 Reset asserted mid-access SHALL drop read_enable/write_enable immediately, without waiting for a clock edge.

Verification
REQ-030 Reset release, enable=1, memory_ready=1, non-memory ALU instruction, no branch -> states 0,1,2,3,5; retire on 5th edge; pc=4; retired_count=1.
REQ-031 Back-to-back ALU instructions, memory_ready=1 -> one retire every 4 cycles; pc 4,8,12.
REQ-032 Load with memory_ready delayed 3 cycles in MEMORY, load_store_address=32'h100, data 32'hDEADBEEF -> read_enable held 4 cycles at 32'h100; load_data=32'hDEADBEEF; register_write_enable pulses once.
REQ-033 branch_taken with target 32'h40 -> pc=32'h40; with target 32'h42 -> ERROR, bus_error=1, pc unchanged.
REQ-034 memory_ready held 0 in FETCH -> ERROR after TIMEOUT=15 cycles; reset_n pulse low -> IDLE, pc=PC_RESET.
REQ-035 pc=32'hFFFF_FFFC, no branch -> pc wraps to 0; enable dropped during EXECUTE -> instruction retires, then IDLE.
